// File: rtl/whack_pkg.sv
// Shared definitions for the whack-a-mole round controller: FSM state
// encoding, LFSR seed/taps and the round-interval table constants.
package whack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT,
    ST_HIT,
    ST_MISS,
    ST_OVER
  } whack_state_t;

  // 8-bit Fibonacci LFSR, taps 8,6,5,4 -> bits 7,5,4,3 of the register.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Round interval: starts at the base and shortens by one every
  // 2**INTERVAL_SHIFT hits, never below the floor.
  localparam int INTERVAL_BASE  = 7;
  localparam int INTERVAL_FLOOR = 1;
  localparam int INTERVAL_SHIFT = 2;

  function automatic logic [2:0] interval_for(input logic [7:0] score_val);
    logic [7:0] step;
    step = score_val >> INTERVAL_SHIFT;
    if (step > 8'(INTERVAL_BASE - INTERVAL_FLOOR))
      step = 8'(INTERVAL_BASE - INTERVAL_FLOOR);
    return 3'(8'(INTERVAL_BASE) - step);
  endfunction

endpackage

// File: rtl/whack_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used to pick the mole hole.
// Only the low two bits leave the block; the seed is loaded on reset.
module whack_lfsr
  import whack_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] seed,
  output logic [1:0] pick
);

  logic [7:0] q;
  logic       fb;

  // XOR of the tapped bits feeds the LSB; a nonzero seed keeps it out of lockup
  always_comb begin
    fb = ^(q & LFSR_TAPS);
  end

  // shift left every enabled cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= seed;
    else if (en)
      q <= {q[6:0], fb};
  end

  assign pick = q[1:0];

endmodule

// File: rtl/whack_round_ctrl.sv
// Whack-a-mole round controller: arms the interval timer, shows one mole
// per round, scores hits and ends the game at the score ceiling.
// Optional macro WHACK_LIVES_EN adds a lives counter; misses then cost a
// life and the game ends when none remain.
//
// state | meaning
// IDLE  | after reset, waiting for start
// ARM   | one cycle, timer load pulse, mole hole chosen
// WAIT  | mole shown, waiting for a press or the timer
// HIT   | one cycle, score update
// MISS  | one cycle, life update (when enabled)
// OVER  | game finished, waiting for start
module whack_round_ctrl
  import whack_pkg::*;
#(
  parameter int NUM_HOLES  = 4,
  parameter int SCORE_MAX  = 99,
  parameter int LIVES_INIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_HOLES-1:0] hit_btn,
  input  logic                 timeout,
  output logic                 tmr_load,
  output logic [2:0]           tmr_interval,
  output logic                 tmr_dir,
  output logic [NUM_HOLES-1:0] mole,
  output logic [7:0]           score,
  output logic [1:0]           lives,
  output logic                 busy,
  output logic                 game_over
);

  localparam int IDX_W = (NUM_HOLES > 1) ? $clog2(NUM_HOLES) : 1;

  whack_state_t         state;
  logic [1:0]           lfsr_pick;
  logic [IDX_W-1:0]     prev_hole;
  logic [IDX_W-1:0]     next_idx;
  logic [31:0]          raw_idx;
  logic [NUM_HOLES-1:0] next_onehot;
  logic [7:0]           score_inc;
  logic                 hit_ok;
  logic                 miss_ev;

  whack_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .en   (1'b1),
    .seed (LFSR_SEED),
    .pick (lfsr_pick)
  );

  assign tmr_dir = 1'b0;

  // hole pick: LFSR bits mod holes, bumped by one if it repeats the last hole
  always_comb begin
    raw_idx = {30'd0, lfsr_pick} % 32'(NUM_HOLES);
    if (raw_idx == 32'(prev_hole))
      raw_idx = (raw_idx + 32'd1) % 32'(NUM_HOLES);
    next_idx    = IDX_W'(raw_idx);
    next_onehot = '0;
    for (int i = 0; i < NUM_HOLES; i++)
      if (32'(i) == raw_idx)
        next_onehot[i] = 1'b1;
  end

  // round outcome decode; a matching bit wins over wrong bits and timeout
  always_comb begin
    hit_ok    = |(hit_btn & mole);
    miss_ev   = (|hit_btn) | timeout;
    score_inc = (score >= 8'(SCORE_MAX)) ? score : score + 8'd1;
  end

`ifdef WHACK_LIVES_EN
  logic [1:0] lives_q;
  assign lives = lives_q;
`else
  assign lives = 2'(LIVES_INIT);
`endif

  // round sequencer with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      mole         <= '0;
      score        <= 8'd0;
      tmr_load     <= 1'b0;
      tmr_interval <= 3'(INTERVAL_BASE);
      busy         <= 1'b0;
      game_over    <= 1'b0;
      prev_hole    <= '0;
`ifdef WHACK_LIVES_EN
      lives_q      <= 2'(LIVES_INIT);
`endif
    end else begin
      tmr_load <= 1'b0;
      case (state)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            state        <= ST_ARM;
            score        <= 8'd0;
            tmr_load     <= 1'b1;
            tmr_interval <= interval_for(8'd0);
            busy         <= 1'b1;
            game_over    <= 1'b0;
`ifdef WHACK_LIVES_EN
            lives_q      <= 2'(LIVES_INIT);
`endif
          end
        end
        ST_ARM: begin
          mole      <= next_onehot;
          prev_hole <= next_idx;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (hit_ok) begin
            mole  <= '0;
            state <= ST_HIT;
          end else if (miss_ev) begin
            mole  <= '0;
            state <= ST_MISS;
          end
        end
        ST_HIT: begin
          score <= score_inc;
          if (score_inc == 8'(SCORE_MAX)) begin
            state     <= ST_OVER;
            busy      <= 1'b0;
            game_over <= 1'b1;
          end else begin
            state        <= ST_ARM;
            tmr_load     <= 1'b1;
            tmr_interval <= interval_for(score_inc);
          end
        end
        ST_MISS: begin
`ifdef WHACK_LIVES_EN
          if (lives_q <= 2'd1) begin
            lives_q   <= 2'd0;
            state     <= ST_OVER;
            busy      <= 1'b0;
            game_over <= 1'b1;
          end else begin
            lives_q      <= lives_q - 2'd1;
            state        <= ST_ARM;
            tmr_load     <= 1'b1;
            tmr_interval <= interval_for(score);
          end
`else
          state        <= ST_ARM;
          tmr_load     <= 1'b1;
          tmr_interval <= interval_for(score);
`endif
        end
        default: begin
          state <= ST_IDLE;
          mole  <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_whack_round_ctrl.sv
// Self-checking bench for whack_round_ctrl with a behavioural game model.
module tb_whack_round_ctrl;

  localparam int N     = 4;
  localparam int SMAX  = 99;
  localparam int LINIT = 3;
`ifdef WHACK_LIVES_EN
  localparam bit LIVES_EN = 1'b1;
`else
  localparam bit LIVES_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         timeout = 1'b0;
  logic [N-1:0] hit_btn = '0;
  logic         tmr_load, tmr_dir, busy, game_over;
  logic [2:0]   tmr_interval;
  logic [N-1:0] mole;
  logic [7:0]   score;
  logic [1:0]   lives;

  logic         start2 = 1'b0;
  logic         timeout2 = 1'b0;
  logic [N-1:0] hit2 = '0;
  logic         tmr_load2, tmr_dir2, busy2, game_over2;
  logic [2:0]   tmr_interval2;
  logic [N-1:0] mole2;
  logic [7:0]   score2;
  logic [1:0]   lives2;

  whack_round_ctrl #(.NUM_HOLES(N), .SCORE_MAX(SMAX), .LIVES_INIT(LINIT)) dut (
    .clk(clk), .rst(rst), .start(start), .hit_btn(hit_btn), .timeout(timeout),
    .tmr_load(tmr_load), .tmr_interval(tmr_interval), .tmr_dir(tmr_dir),
    .mole(mole), .score(score), .lives(lives), .busy(busy), .game_over(game_over)
  );

  whack_round_ctrl #(.NUM_HOLES(N), .SCORE_MAX(2), .LIVES_INIT(LINIT)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .hit_btn(hit2), .timeout(timeout2),
    .tmr_load(tmr_load2), .tmr_interval(tmr_interval2), .tmr_dir(tmr_dir2),
    .mole(mole2), .score(score2), .lives(lives2), .busy(busy2), .game_over(game_over2)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int         m_score = 0;
  int         m_lives = LINIT;
  int         m_prev_idx = 0;
  bit         m_over = 1'b1;
  logic [7:0] m_lfsr;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic int exp_interval(input int s);
    int r;
    r = s / 4;
    if (r > 6) r = 6;
    return 7 - r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= lfsr_next(m_lfsr);
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_game;
    start = 1'b1;
    tick();
    start = 1'b0;
    m_score = 0;
    m_lives = LINIT;
    m_over  = 1'b0;
    n_vec++;
    if ({tmr_load, busy, game_over, score, lives, tmr_interval} !==
        {1'b1, 1'b1, 1'b0, 8'd0, 2'(LINIT), 3'd7}) begin
      n_err++;
      $display("FAIL start_game: load/busy/over/score/lives/intv = %b/%b/%b/%0d/%0d/%0d, required 1/1/0/0/%0d/7",
               tmr_load, busy, game_over, score, lives, tmr_interval, LINIT);
    end
  endtask

  // kind: 0 hit, 1 hit+timeout, 2 hit+wrong bit, 3 wrong bit only, 4 timeout
  task automatic play_round(input int kind, input bit noise);
    logic [N-1:0] exp, other;
    int idx, idle;
    idx = int'(m_lfsr[1:0]) % N;
    if (idx == m_prev_idx) idx = (idx + 1) % N;
    exp = '0;
    exp[idx] = 1'b1;
    other = {exp[N-2:0], exp[N-1]};

    n_vec++;
    if ({tmr_load, busy, game_over, mole} !== {1'b1, 1'b1, 1'b0, {N{1'b0}}}) begin
      n_err++;
      $display("FAIL arm_status: load/busy/over/mole = %b/%b/%b/%b, required 1/1/0/0000",
               tmr_load, busy, game_over, mole);
    end
    n_vec++;
    if (tmr_interval !== 3'(exp_interval(m_score))) begin
      n_err++;
      $display("FAIL interval: got %0d, required %0d (score %0d)", tmr_interval, exp_interval(m_score), m_score);
    end
    n_vec++;
    if (dut.u_lfsr.q !== m_lfsr || m_lfsr == 8'h00) begin
      n_err++;
      $display("FAIL lfsr: got %h, required %h (nonzero)", dut.u_lfsr.q, m_lfsr);
    end

    if (noise) begin
      hit_btn = N'($urandom_range(1, (1 << N) - 1));
      timeout = 1'b1;
      start   = 1'b1;
    end
    tick();
    hit_btn = '0; timeout = 1'b0; start = 1'b0;
    m_prev_idx = idx;
    n_vec++;
    if (mole !== exp || {tmr_load, busy} !== 2'b01) begin
      n_err++;
      $display("FAIL wait_mole: mole %b load %b busy %b, required mole %b load 0 busy 1", mole, tmr_load, busy, exp);
    end

    idle = $urandom_range(0, 2);
    for (int k = 0; k < idle; k++) begin
      if (noise) start = 1'b1;
      tick();
      start = 1'b0;
      n_vec++;
      if (mole !== exp || busy !== 1'b1) begin
        n_err++;
        $display("FAIL wait_hold: mole %b busy %b, required mole %b busy 1", mole, busy, exp);
      end
    end

    case (kind)
      0: hit_btn = exp;
      1: begin hit_btn = exp; timeout = 1'b1; end
      2: hit_btn = exp | other;
      3: hit_btn = other;
      default: timeout = 1'b1;
    endcase
    tick();
    hit_btn = '0; timeout = 1'b0;
    n_vec++;
    if ({busy, game_over, mole} !== {1'b1, 1'b0, {N{1'b0}}}) begin
      n_err++;
      $display("FAIL resolve: busy %b over %b mole %b, required 1 0 0000", busy, game_over, mole);
    end
    tick();

    if (kind <= 2) begin
      if (m_score < SMAX) m_score++;
      if (m_score == SMAX) m_over = 1'b1;
    end else if (LIVES_EN) begin
      m_lives--;
      if (m_lives == 0) m_over = 1'b1;
    end
    n_vec++;
    if ({score, lives} !== {8'(m_score), 2'(m_lives)}) begin
      n_err++;
      $display("FAIL score_lives: score %0d lives %0d, required score %0d lives %0d", score, lives, m_score, m_lives);
    end
    n_vec++;
    if (m_over) begin
      if ({game_over, busy, tmr_load, mole} !== {1'b1, 1'b0, 1'b0, {N{1'b0}}}) begin
        n_err++;
        $display("FAIL over: over %b busy %b load %b mole %b, required 1 0 0 0000", game_over, busy, tmr_load, mole);
      end
    end else if ({game_over, busy, tmr_load} !== 3'b011) begin
      n_err++;
      $display("FAIL rearm: over %b busy %b load %b, required 0 1 1", game_over, busy, tmr_load);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({mole, score, lives, tmr_load, tmr_interval, busy, game_over, tmr_dir} !==
        {{N{1'b0}}, 8'd0, 2'(LINIT), 1'b0, 3'd7, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_outputs: mole %b score %0d lives %0d load %b intv %0d busy %b over %b dir %b, required 0 0 %0d 0 7 0 0 0",
               mole, score, lives, tmr_load, tmr_interval, busy, game_over, tmr_dir, LINIT);
    end
    n_vec++;
    if (dut.u_lfsr.q !== 8'hA5) begin
      n_err++;
      $display("FAIL reset_lfsr: got %h, required a5", dut.u_lfsr.q);
    end
    rst = 1'b0;
    m_prev_idx = 0;
    m_over = 1'b1;
    repeat (2) begin
      tick();
      n_vec++;
      if ({busy, tmr_load, game_over, mole} !== {3'b000, {N{1'b0}}}) begin
        n_err++;
        $display("FAIL idle_hold: busy %b load %b over %b mole %b, required all 0", busy, tmr_load, game_over, mole);
      end
    end
  endtask

  task automatic test_start_hit;
    start_game();
    play_round(0, 1'b0);
  endtask

  task automatic test_interval;
    while (m_score < 28) play_round(0, 1'b0);
  endtask

  task automatic test_hit_timeout;
    if (m_over) start_game();
    play_round(1, 1'b0);
    play_round(2, 1'b0);
  endtask

  task automatic test_misses;
    int cnt;
    if (m_over) start_game();
    cnt = 0;
    while (!m_over && cnt < 10) begin
      play_round(4, 1'b0);
      cnt++;
    end
    n_vec++;
    if (cnt !== (LIVES_EN ? LINIT : 10)) begin
      n_err++;
      $display("FAIL miss_count: game lasted %0d timeouts, required %0d", cnt, LIVES_EN ? LINIT : 10);
    end
    if (m_over) start_game();
    play_round(3, 1'b0);
  endtask

  task automatic test_score_max;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      tick();
      hit2 = '1;
      tick();
      hit2 = '0;
      tick();
      n_vec++;
      if ({score2, game_over2, busy2} !== {8'(i), (i == 2), (i != 2)}) begin
        n_err++;
        $display("FAIL score_max: round %0d score %0d over %b busy %b, required score %0d over %b busy %b",
                 i, score2, game_over2, busy2, i, (i == 2), (i != 2));
      end
    end
  endtask

  task automatic test_async_reset;
    if (m_over) start_game();
    tick();
    n_vec++;
    if (mole === '0) begin
      n_err++;
      $display("FAIL pre_reset_mole: got %b, required nonzero", mole);
    end
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({mole, busy, tmr_load, score} !== {{N{1'b0}}, 1'b0, 1'b0, 8'd0}) begin
      n_err++;
      $display("FAIL async_reset: mole %b busy %b load %b score %0d, required 0 0 0 0", mole, busy, tmr_load, score);
    end
    #2;
    rst = 1'b0;
    m_prev_idx = 0;
    m_score = 0;
    m_lives = LINIT;
    m_over = 1'b1;
    repeat (2) begin
      tick();
      n_vec++;
      if ({tmr_load, busy, game_over} !== 3'b000) begin
        n_err++;
        $display("FAIL post_reset: load %b busy %b over %b, required 0 0 0", tmr_load, busy, game_over);
      end
    end
  endtask

  task automatic test_random;
    int kind;
    for (int r = 0; r < 1000; r++) begin
      if (m_over) start_game();
      kind = $urandom_range(0, 9);
      if (kind > 4) kind = 0;
      play_round(kind, $urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    test_reset();
    test_start_hit();
    test_interval();
    test_hit_timeout();
    test_misses();
    test_score_max();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
